// File: rtl/final_soc_pio_pkg.sv
// Shared definitions for the LED PIO: register offsets and STATUS bit positions.
package final_soc_pio_pkg;

  localparam int ADDR_W = 3;
  localparam int BUS_W  = 32;

  typedef enum logic [ADDR_W-1:0] {
    OFF_DATA   = 3'd0,
    OFF_SET    = 3'd1,
    OFF_CLEAR  = 3'd2,
    OFF_BMASK  = 3'd3,
    OFF_BPER   = 3'd4,
    OFF_DUTY   = 3'd5,
    OFF_STATUS = 3'd6,
    OFF_RSVD   = 3'd7
  } reg_off_e;

  localparam int STATUS_PHASE_BIT = 0;
  localparam int STATUS_PWM_BIT   = 1;

endpackage

// File: rtl/final_soc_led_pio_pwm_if.sv
// Avalon-MM slave port of the LED PIO: zero wait states, combinational read data.
interface final_soc_led_pio_pwm_if;
  import final_soc_pio_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [BUS_W-1:0]  writedata;
  logic [BUS_W-1:0]  readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/final_soc_blink_timer.sv
// Half-period blink timer: toggles phase every 'period' clocks; period 0 parks it at phase 0.
module final_soc_blink_timer #(
  parameter int BLINK_W = 26
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [BLINK_W-1:0] period,
  input  logic               restart,
  output logic               phase
);

  logic [BLINK_W-1:0] bcnt_q, bcnt_d;
  logic               phase_q, phase_d;

  // NOTE: next-state defaults come first so every path assigns every _d and no latch is inferred.
  always_comb begin
    bcnt_d  = bcnt_q + BLINK_W'(1);
    phase_d = phase_q;
    if (restart || (period == '0)) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (bcnt_q >= period - BLINK_W'(1)) begin
      // >= rather than == keeps the counter bounded if it ever sits above the terminal count.
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/final_soc_led_pio_pwm.sv
// Avalon-MM LED output PIO with atomic SET/CLEAR, per-bit blink and global PWM dimming.
module final_soc_led_pio_pwm
  import final_soc_pio_pkg::*;
#(
  parameter int               WIDTH          = 14,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0,
  parameter int               BLINK_W        = 26,
  parameter logic [BLINK_W-1:0] DEFAULT_PERIOD = BLINK_W'(25_000_000),
  parameter int               PWM_W          = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  final_soc_led_pio_pwm_if.slave  bus,
  output logic [WIDTH-1:0]        out_port
);

  logic [WIDTH-1:0]   data_q,  data_d;
  logic [WIDTH-1:0]   bmask_q, bmask_d;
  logic [BLINK_W-1:0] bper_q,  bper_d;
  logic [PWM_W-1:0]   duty_q,  duty_d;
  logic [PWM_W-1:0]   pcnt_q;
  logic [WIDTH-1:0]   out_q,   out_d;

  logic     wr_en;
  logic     bper_restart;
  logic     phase;
  logic     pwm_on;
  reg_off_e reg_sel;
  logic     unused_wd;

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign reg_sel      = reg_off_e'(bus.address);
  assign bper_restart = wr_en && (reg_sel == OFF_BPER);
  // Upper writedata bits beyond each register's width are intentionally dropped.
  assign unused_wd    = ^bus.writedata;

  always_comb begin
    data_d  = data_q;
    bmask_d = bmask_q;
    bper_d  = bper_q;
    duty_d  = duty_q;
    if (wr_en) begin
      unique case (reg_sel)
        OFF_DATA:  data_d  = bus.writedata[WIDTH-1:0];
        OFF_SET:   data_d  = data_q | bus.writedata[WIDTH-1:0];
        OFF_CLEAR: data_d  = data_q & ~bus.writedata[WIDTH-1:0];
        OFF_BMASK: bmask_d = bus.writedata[WIDTH-1:0];
        OFF_BPER:  bper_d  = bus.writedata[BLINK_W-1:0];
        OFF_DUTY:  duty_d  = bus.writedata[PWM_W-1:0];
        default:   ;
      endcase
    end
  end

  final_soc_blink_timer #(
    .BLINK_W (BLINK_W)
  ) u_blink (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (bper_q),
    .restart (bper_restart),
    .phase   (phase)
  );

  // All-ones duty means fully on; otherwise the LEDs would drop out for one count per cycle.
  assign pwm_on = (pcnt_q < duty_q) || (duty_q == '1);
  assign out_d  = data_q & ~(bmask_q & {WIDTH{phase}}) & {WIDTH{pwm_on}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= RESET_VALUE;
      bmask_q <= '0;
      bper_q  <= DEFAULT_PERIOD;
      duty_q  <= '1;
      pcnt_q  <= '0;
      out_q   <= RESET_VALUE;
    end else begin
      data_q  <= data_d;
      bmask_q <= bmask_d;
      bper_q  <= bper_d;
      duty_q  <= duty_d;
      pcnt_q  <= pcnt_q + PWM_W'(1);
      out_q   <= out_d;
    end
  end

  assign out_port = out_q;

  always_comb begin
    bus.readdata = '0;
    unique case (reg_sel)
      OFF_DATA:  bus.readdata = BUS_W'(data_q);
      OFF_BMASK: bus.readdata = BUS_W'(bmask_q);
      OFF_BPER:  bus.readdata = BUS_W'(bper_q);
      OFF_DUTY:  bus.readdata = BUS_W'(duty_q);
      OFF_STATUS: begin
        bus.readdata[STATUS_PHASE_BIT] = phase;
        bus.readdata[STATUS_PWM_BIT]   = pwm_on;
      end
      default:   ;
    endcase
  end

endmodule
